lfsr_seq_ctrl: RTL and testbench

- Run controller for the 8-bit display/LFSR shift register datapath (clk, clr, qs[7:0]).
- Loads a seed and generates step enables at a programmable prescaled rate.
- Counts steps, stops after N steps or on request, and flags all-zero lockup.
- Sits between the board control logic (buttons/switches) and the shift register; the shift register only shifts when sr_step is high.

---
 rtl/lfsr_seq_ctrl_if.sv | 49 ++++
 rtl/lfsr_seq_ctrl.sv | 170 +++++++++++++++++
 tb/tb_lfsr_seq_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_seq_ctrl_if.sv
// Board-control and shift-register signal bundle for lfsr_seq_ctrl.
// period/period_valid exist only when LFSR_PERIOD_DET_EN is defined.
interface lfsr_seq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16,
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] seed;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] steps;
  logic [WIDTH-1:0] sr_q;

  logic             sr_load;
  logic [WIDTH-1:0] sr_seed;
  logic             sr_step;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] step_cnt;
  logic             lockup;

`ifdef LFSR_PERIOD_DET_EN
  logic [CNT_W-1:0] period;
  logic             period_valid;

  modport master (
    input  start, stop, seed, div, steps, sr_q,
    output sr_load, sr_seed, sr_step, busy, done, step_cnt, lockup,
    output period, period_valid
  );

  modport slave (
    output start, stop, seed, div, steps, sr_q,
    input  sr_load, sr_seed, sr_step, busy, done, step_cnt, lockup,
    input  period, period_valid
  );
`else
  modport master (
    input  start, stop, seed, div, steps, sr_q,
    output sr_load, sr_seed, sr_step, busy, done, step_cnt, lockup
  );

  modport slave (
    output start, stop, seed, div, steps, sr_q,
    input  sr_load, sr_seed, sr_step, busy, done, step_cnt, lockup
  );
`endif
endinterface

// File: rtl/lfsr_seq_ctrl.sv
// Run controller for the LFSR/display shift register: seed load, prescaled steps, step limit, lockup flag.
// Define LFSR_PERIOD_DET_EN to add the period detector (period/period_valid outputs).
module lfsr_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            clr,
  lfsr_seq_ctrl_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // An all-zero seed would park the register in its lockup state.
  function automatic logic [WIDTH-1:0] safe_seed(input logic [WIDTH-1:0] s);
    return (s == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : s;
  endfunction

  logic [1:0]       state_q,    state_d;
  logic [WIDTH-1:0] seed_q,     seed_d;
  logic [DIV_W-1:0] div_q,      div_d;
  logic [DIV_W-1:0] psc_q,      psc_d;
  logic [CNT_W-1:0] steps_q,    steps_d;
  logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic             lockup_q,   lockup_d;
  logic             sr_load_q,  sr_load_d;
  logic             sr_step_q,  sr_step_d;
  logic             busy_q,     busy_d;
  logic             done_q,     done_d;

  logic start_acc;
  logic sr_zero;
  logic limit_hit;
  logic tick;

  assign start_acc = (state_q == S_IDLE) && bus.start && !bus.stop;
  assign sr_zero   = (bus.sr_q == '0);
  assign limit_hit = (steps_q != '0) && (step_cnt_q == steps_q);
  assign tick      = (psc_q == div_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_acc) state_d = S_LOAD;
      S_LOAD:  state_d = bus.stop ? S_DONE : S_RUN;
      S_RUN:   if (bus.stop || sr_zero || limit_hit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The final step is issued with the count reaching the limit; the exit
  // happens on the following cycle, once that step has been applied.
  always_comb begin
    seed_d     = seed_q;
    div_d      = div_q;
    steps_d    = steps_q;
    psc_d      = psc_q;
    step_cnt_d = step_cnt_q;
    lockup_d   = lockup_q;
    sr_step_d  = 1'b0;
    if (start_acc) begin
      seed_d     = safe_seed(bus.seed);
      div_d      = bus.div;
      steps_d    = bus.steps;
      psc_d      = '0;
      step_cnt_d = '0;
      lockup_d   = 1'b0;
    end else if (state_q == S_RUN && !bus.stop) begin
      if (sr_zero) begin
        lockup_d = 1'b1;
      end else if (!limit_hit) begin
        if (tick) begin
          psc_d      = '0;
          sr_step_d  = 1'b1;
          step_cnt_d = step_cnt_q + 1'b1;
        end else begin
          psc_d = psc_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    sr_load_d = (state_d == S_LOAD);
    busy_d    = (state_d == S_LOAD) || (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q    <= S_IDLE;
      seed_q     <= '0;
      div_q      <= '0;
      psc_q      <= '0;
      steps_q    <= '0;
      step_cnt_q <= '0;
      lockup_q   <= 1'b0;
      sr_load_q  <= 1'b0;
      sr_step_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      seed_q     <= seed_d;
      div_q      <= div_d;
      psc_q      <= psc_d;
      steps_q    <= steps_d;
      step_cnt_q <= step_cnt_d;
      lockup_q   <= lockup_d;
      sr_load_q  <= sr_load_d;
      sr_step_q  <= sr_step_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.sr_load  = sr_load_q;
  assign bus.sr_seed  = seed_q;
  assign bus.sr_step  = sr_step_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.step_cnt = step_cnt_q;
  assign bus.lockup   = lockup_q;

`ifdef LFSR_PERIOD_DET_EN
  // sr_q shows a step one cycle after sr_step, so the compare and the
  // count belonging to that step are both delayed by one cycle.
  logic             chk_q,          chk_d;
  logic [CNT_W-1:0] chk_cnt_q,      chk_cnt_d;
  logic [CNT_W-1:0] period_q,       period_d;
  logic             period_valid_q, period_valid_d;

  always_comb begin
    chk_d          = sr_step_q;
    chk_cnt_d      = step_cnt_q;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    if (start_acc) begin
      period_d       = '0;
      period_valid_d = 1'b0;
    end else if (state_q == S_RUN && chk_q && !period_valid_q && bus.sr_q == seed_q) begin
      period_d       = chk_cnt_q;
      period_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      chk_q          <= 1'b0;
      chk_cnt_q      <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
    end else begin
      chk_q          <= chk_d;
      chk_cnt_q      <= chk_cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = period_valid_q;
`endif

endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl: table of directed runs, randomized runs against an event-schedule model,
// and hand sequences for reset, start/stop collisions, sticky lockup and (with LFSR_PERIOD_DET_EN) period.
module tb_lfsr_seq_ctrl;
  localparam int WIDTH = 8;
  localparam int DIV_W = 16;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic clr;

  lfsr_seq_ctrl_if #(.WIDTH(WIDTH), .DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  lfsr_seq_ctrl #(.WIDTH(WIDTH), .DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Shift register under control: maximal-length x^8+x^6+x^5+x^4+1.
  logic [7:0] sr_model;
  logic       zero_force;
  always @(posedge clk) begin
    if (!clr)             sr_model <= 8'h00;
    else if (bus.sr_load) sr_model <= bus.sr_seed;
    else if (bus.sr_step) sr_model <= {sr_model[6:0], sr_model[7] ^ sr_model[5] ^ sr_model[4] ^ sr_model[3]};
  end
  assign bus.sr_q = zero_force ? 8'h00 : sr_model;

  typedef struct {
    logic [7:0] seed;
    int         div;
    int         steps;
    int         stop_at;
    int         zero_at;
    logic [7:0] x_seed;
    int         x_cnt;
    bit         x_lock;
    int         x_done;
  } vec_t;

  int nvec = 0;
  int nerr = 0;
  int run_id = 0;

  function automatic logic [63:0] pk(input logic ld, input logic st, input logic bz, input logic dn,
                                     input logic lk, input logic [15:0] cnt, input logic [7:0] sd);
    return {35'd0, ld, st, bz, dn, lk, cnt, sd};
  endfunction

  function automatic logic [63:0] outs_raw();
    return pk(bus.sr_load, bus.sr_step, bus.busy, bus.done, bus.lockup, bus.step_cnt, bus.sr_seed);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycle c=1 is the LOAD cycle right after the edge that accepts start.
  // Step j is visible at t_j = 2 + j*(div+1); the run decides to end in cycle e
  // (stop, zero sr_q, or the cycle showing the last step) and done shows at e+1.
  task automatic run_case(input vec_t v, input bit noise, input bit has_x);
    int per, tn, e, k, d, cc, n;
    bit lk;
    logic [7:0] fseed;
    logic [63:0] act, exp;
    run_id++;
    per   = v.div + 1;
    tn    = (v.steps != 0) ? 2 + v.steps * per : 32'h3fff_ffff;
    e     = tn;
    lk    = 1'b0;
    if (v.zero_at >= 2 && v.zero_at <= e) begin e = v.zero_at; lk = 1'b1; end
    if (v.stop_at >= 1 && v.stop_at <= e) begin e = v.stop_at; lk = 1'b0; end
    k     = (e < 3) ? 0 : (e - 2) / per;
    d     = e + 1;
    fseed = (v.seed == 8'h00) ? 8'h01 : v.seed;

    @(negedge clk);
    bus.seed  = v.seed;
    bus.div   = 16'(v.div);
    bus.steps = 16'(v.steps);
    bus.start = 1'b1;
    bus.stop  = 1'b0;
    for (int c = 1; c <= d + 2; c++) begin
      @(negedge clk);
      bus.start  = (noise && c <= d) ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.stop   = (c == v.stop_at);
      zero_force = (v.zero_at >= 2 && c >= v.zero_at);
      cc  = (c < e) ? c : e;
      n   = (cc < 3) ? 0 : (cc - 2) / per;
      exp = pk(c == 1, (c >= 3 && c <= e && (c - 2) % per == 0), c < d, c == d,
               (c >= d) ? lk : 1'b0, 16'(n), (c == 1) ? fseed : 8'h00);
      act = pk(bus.sr_load, bus.sr_step, bus.busy, bus.done, bus.lockup, bus.step_cnt,
               (c == 1) ? bus.sr_seed : 8'h00);
      check($sformatf("run%0d_cyc%0d", run_id, c), act, exp);
      if (has_x && c == 1)
        check($sformatf("run%0d_sr_seed", run_id), {56'd0, bus.sr_seed}, {56'd0, v.x_seed});
      if (has_x && c == v.x_done)
        check($sformatf("run%0d_end_done_cnt_lock", run_id),
              {46'd0, bus.done, bus.step_cnt, bus.lockup}, {46'd0, 1'b1, 16'(v.x_cnt), v.x_lock});
    end
    bus.stop   = 1'b0;
    zero_force = 1'b0;
  endtask

  vec_t tbl [8];
  vec_t rv;

  initial begin
    tbl[0] = '{8'hA5, 3, 5, 0, 0, 8'hA5, 5, 1'b0, 23};
    tbl[1] = '{8'h00, 0, 2, 0, 0, 8'h01, 2, 1'b0, 5};
    tbl[2] = '{8'h3C, 0, 0, 9, 0, 8'h3C, 7, 1'b0, 10};
    tbl[3] = '{8'h5A, 1, 0, 0, 7, 8'h5A, 2, 1'b1, 8};
    tbl[4] = '{8'h33, 2, 4, 1, 0, 8'h33, 0, 1'b0, 2};
    tbl[5] = '{8'h81, 0, 0, 5, 5, 8'h81, 3, 1'b0, 6};
    tbl[6] = '{8'hC3, 1, 3, 0, 8, 8'hC3, 3, 1'b1, 9};
    tbl[7] = '{8'h01, 5, 1, 0, 0, 8'h01, 1, 1'b0, 9};

    clr        = 1'b0;
    zero_force = 1'b0;
    bus.start  = 1'b1;
    bus.stop   = 1'b0;
    bus.seed   = 8'h5A;
    bus.div    = 16'd0;
    bus.steps  = 16'd0;

    // Reset held with start requested: everything stays at zero.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("reset_hold%0d", i), outs_raw(), 64'd0);
    end

    // start together with stop in IDLE is ignored.
    clr      = 1'b1;
    bus.stop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("start_with_stop%0d", i), outs_raw(), 64'd0);
    end
    bus.start = 1'b0;
    bus.stop  = 1'b0;

    for (int i = 0; i < 8; i++) run_case(tbl[i], 1'b0, 1'b1);

    // Lockup stays set through idle cycles.
    run_case(tbl[3], 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("lockup_sticky%0d", i), {61'd0, bus.busy, bus.done, bus.lockup}, {61'd0, 3'b001});
    end

    for (int i = 0; i < 40; i++) begin
      rv.seed    = 8'($urandom);
      if ($urandom_range(0, 4) == 0) rv.seed = 8'h00;
      rv.div     = $urandom_range(0, 4);
      rv.steps   = $urandom_range(0, 6);
      rv.stop_at = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0;
      rv.zero_at = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 30) : 0;
      if (rv.steps == 0 && rv.stop_at == 0 && rv.zero_at == 0) rv.stop_at = $urandom_range(2, 30);
      rv.x_seed  = 8'h00;
      rv.x_cnt   = 0;
      rv.x_lock  = 1'b0;
      rv.x_done  = 0;
      run_case(rv, 1'b1, 1'b0);
    end

    // Reset in the middle of a free run aborts with no done pulse.
    @(negedge clk);
    bus.seed  = 8'h77;
    bus.div   = 16'd1;
    bus.steps = 16'd0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 9; i++) @(negedge clk);
    check("midrun_busy", {63'd0, bus.busy}, 64'd1);
    clr = 1'b0;
    @(negedge clk);
    check("midrun_reset", outs_raw(), 64'd0);
    clr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("after_midrun_reset%0d", i), outs_raw(), 64'd0);
    end

`ifdef LFSR_PERIOD_DET_EN
    begin
      int cyc;
      @(negedge clk);
      bus.seed  = 8'h01;
      bus.div   = 16'd0;
      bus.steps = 16'd0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("period_cleared", {47'd0, bus.period_valid, bus.period}, 64'd0);
      cyc = 0;
      while (!bus.period_valid && cyc < 400) begin
        @(negedge clk);
        cyc++;
      end
      check("period_255", {47'd0, bus.period_valid, bus.period}, {47'd0, 1'b1, 16'd255});
      check("period_run_continues", {63'd0, bus.busy}, 64'd1);
      bus.stop = 1'b1;
      @(negedge clk);
      bus.stop = 1'b0;
      check("period_stop_done", {62'd0, bus.done, bus.period_valid}, 64'd3);
      @(negedge clk);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
